// File: rtl/rca_4bit.sv
// 4-bit ripple-carry adder built from gate-level full-adder cells, with a
// registered SUM/Cout/OVF output stage (1-cycle latency, async active-high reset).
module rca_4bit (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] SUM,
    output logic       Cout,
    output logic       OVF
);

    logic [4:0] w_c;
    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [3:0] w_s;

    logic [3:0] r_sum;
    logic       r_cout;
    logic       r_ovf;

    assign w_c[0] = Cin;

    // Carry strictly ripples bit 0 -> bit 3; no lookahead.
    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign w_p[i]   = A[i] ^ B[i];
        assign w_g[i]   = A[i] & B[i];
        assign w_s[i]   = w_p[i] ^ w_c[i];
        assign w_c[i+1] = w_g[i] | (w_c[i] & w_p[i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum  <= 4'h0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_sum  <= w_s;
            r_cout <= w_c[4];
            r_ovf  <= w_c[3] ^ w_c[4];
        end
    end

    assign SUM  = r_sum;
    assign Cout = r_cout;
    assign OVF  = r_ovf;

endmodule

// File: tb/tb_rca_4bit.sv
// Self-checking bench for rca_4bit: directed spec cases, exhaustive sweep and
// randomized traffic against an arithmetic reference model.
module tb_rca_4bit;

    logic       clk;
    logic       rst;
    logic [3:0] A;
    logic [3:0] B;
    logic       Cin;
    logic [3:0] SUM;
    logic       Cout;
    logic       OVF;

    int checks;
    int errors;

    rca_4bit dut (
        .clk  (clk),
        .rst  (rst),
        .A    (A),
        .B    (B),
        .Cin  (Cin),
        .SUM  (SUM),
        .Cout (Cout),
        .OVF  (OVF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact 5-bit unsigned sum, overflow from the signed result range.
    function automatic logic [5:0] model(input logic [3:0] a, input logic [3:0] b,
                                         input logic ci);
        int u;
        int sa;
        int sb;
        int s;
        logic [31:0] uv;
        logic ovf;
        u  = a + b + ci;
        sa = $signed(a);
        sb = $signed(b);
        s  = sa + sb + int'(ci);
        ovf = (s > 7) || (s < -8);
        uv = u;
        return {ovf, uv[4:0]};
    endfunction

    task automatic test_reset();
        logic [5:0] exp;
        // Get a nonzero result into the register first.
        @(negedge clk);
        rst = 1'b0;
        A = 4'hF; B = 4'hF; Cin = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({OVF, Cout, SUM} !== 6'b01_1111) begin
            errors++;
            $display("FAIL reset_preload got %b exp %b", {OVF, Cout, SUM}, 6'b01_1111);
        end
        // Assert reset between edges; outputs must clear without a clock edge.
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({OVF, Cout, SUM} !== 6'b0) begin
            errors++;
            $display("FAIL reset_async got %b exp %b", {OVF, Cout, SUM}, 6'b0);
        end
        @(posedge clk); #1;
        checks++;
        if ({OVF, Cout, SUM} !== 6'b0) begin
            errors++;
            $display("FAIL reset_hold got %b exp %b", {OVF, Cout, SUM}, 6'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        A = 4'h9; B = 4'h8; Cin = 1'b0;
        #2;
        checks++;
        if ({OVF, Cout, SUM} !== 6'b0) begin
            errors++;
            $display("FAIL reset_release_early got %b exp %b", {OVF, Cout, SUM}, 6'b0);
        end
        exp = model(4'h9, 4'h8, 1'b0);
        @(posedge clk); #1;
        checks++;
        if ({OVF, Cout, SUM} !== exp) begin
            errors++;
            $display("FAIL reset_first_capture got %b exp %b", {OVF, Cout, SUM}, exp);
        end
    endtask

    // Directed cases: {A, B, Cin} and expected {OVF, Cout, SUM} from the arithmetic.
    task automatic test_directed();
        logic [8:0] stim [9];
        logic [5:0] want [9];
        stim[0] = {4'h3, 4'hD, 1'b1}; want[0] = {1'b0, 1'b1, 4'h1};
        stim[1] = {4'h7, 4'hB, 1'b1}; want[1] = {1'b0, 1'b1, 4'h3};
        stim[2] = {4'hF, 4'hE, 1'b1}; want[2] = {1'b0, 1'b1, 4'hE};
        stim[3] = {4'hA, 4'hA, 1'b1}; want[3] = {1'b1, 1'b1, 4'h5};
        stim[4] = {4'h9, 4'h8, 1'b0}; want[4] = {1'b1, 1'b1, 4'h1};
        stim[5] = {4'h4, 4'h3, 1'b0}; want[5] = {1'b0, 1'b0, 4'h7};
        stim[6] = {4'hF, 4'h0, 1'b1}; want[6] = {1'b0, 1'b1, 4'h0};
        stim[7] = {4'hF, 4'hF, 1'b1}; want[7] = {1'b0, 1'b1, 4'hF};
        stim[8] = {4'h0, 4'h0, 1'b0}; want[8] = {1'b0, 1'b0, 4'h0};
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            {A, B, Cin} = stim[i];
            @(posedge clk); #1;
            checks++;
            if ({OVF, Cout, SUM} !== want[i]) begin
                errors++;
                $display("FAIL directed_%0d A=%h B=%h Cin=%b got %b exp %b",
                         i, stim[i][8:5], stim[i][4:1], stim[i][0], {OVF, Cout, SUM},
                         want[i]);
            end
        end
    endtask

    task automatic test_exhaustive();
        logic [5:0] exp;
        for (int n = 0; n < 512; n++) begin
            @(negedge clk);
            {A, B, Cin} = 9'(n);
            exp = model(A, B, Cin);
            @(posedge clk); #1;
            checks++;
            if ({OVF, Cout, SUM} !== exp) begin
                errors++;
                $display("FAIL exhaustive A=%h B=%h Cin=%b got %b exp %b",
                         A, B, Cin, {OVF, Cout, SUM}, exp);
            end
        end
    endtask

    // Back-to-back random inputs; also confirm outputs hold until the next edge.
    task automatic test_back_to_back();
        logic [5:0] exp;
        logic [5:0] prev;
        prev = {OVF, Cout, SUM};
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            A   = 4'($urandom_range(15));
            B   = 4'($urandom_range(15));
            Cin = 1'($urandom_range(1));
            exp = model(A, B, Cin);
            #1;
            checks++;
            if ({OVF, Cout, SUM} !== prev) begin
                errors++;
                $display("FAIL latency_hold got %b exp %b", {OVF, Cout, SUM}, prev);
            end
            @(posedge clk); #1;
            checks++;
            if ({OVF, Cout, SUM} !== exp) begin
                errors++;
                $display("FAIL random A=%h B=%h Cin=%b got %b exp %b",
                         A, B, Cin, {OVF, Cout, SUM}, exp);
            end
            prev = exp;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        A = 4'h0; B = 4'h0; Cin = 1'b0;
        #3;
        checks++;
        if ({OVF, Cout, SUM} !== 6'b0) begin
            errors++;
            $display("FAIL power_on_reset got %b exp %b", {OVF, Cout, SUM}, 6'b0);
        end
        test_reset();
        test_directed();
        test_exhaustive();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
